// File: rtl/edge_detection_stream.sv
// Streaming 3x3 binary edge detector over a raster-ordered pixel stream.
// Two line buffers and a 3x3 window hold the neighbourhood; output lags input
// by IMG_WIDTH+1 pixels, and the tail of each frame is flushed with zero padding.
module edge_detection_stream #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned MODE       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_pixel,
    output logic in_ready,
    output logic out_valid,
    output logic out_edge,
    output logic out_last,
    input  logic out_ready,
    output logic busy
);
    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   icol_q, icol_d, ocol_q;
    logic [RW-1:0]   irow_q, irow_d, orow_q;
    logic            in_xfer, produce, shift_en, pix;
    logic [IMG_WIDTH-1:0] lb0, lb1;
    logic [2:0]      win_top, win_mid, win_bot;
    logic            top_ok, bot_ok, lft_ok, rgt_ok;
    logic            c_px, n_px, s_px, w_px, e_px, nw_px, ne_px, sw_px, se_px;
    logic [2:0]      cross_cnt;
    logic            edge_c;

    // Next-state, input handshake and input raster position
    always_comb begin
        state_d  = state_q;
        icol_d   = icol_q;
        irow_d   = irow_q;
        in_ready = 1'b0;
        produce  = 1'b0;
        if (!rst && state_q != FLUSH) begin
            in_ready = !out_valid || out_ready;
        end
        in_xfer = in_valid && in_ready;
        if (in_xfer) begin
            if (icol_q == COL_LAST) begin
                icol_d = '0;
                irow_d = (irow_q == ROW_LAST) ? '0 : irow_q + 1'b1;
            end else begin
                icol_d = icol_q + 1'b1;
            end
        end
        case (state_q)
            FILL: begin
                // Transfer at index IMG_WIDTH (row 1, col 0) completes the fill
                if (in_xfer && irow_q == RW'(1) && icol_q == '0) state_d = RUN;
            end
            RUN: begin
                produce = in_xfer;
                if (in_xfer && irow_q == ROW_LAST && icol_q == COL_LAST) state_d = FLUSH;
            end
            FLUSH: begin
                // Stop producing once the last output is loaded, until it leaves
                produce = (!out_valid || out_ready) && !(out_valid && out_last);
                if (out_valid && out_ready && out_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Raster counters, output register, boundary masks and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icol_q    <= '0;
            irow_q    <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            top_ok    <= 1'b0;
            bot_ok    <= 1'b0;
            lft_ok    <= 1'b0;
            rgt_ok    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            icol_q <= icol_d;
            irow_q <= irow_d;
            busy   <= (state_d != FILL) || (icol_d != '0) || (irow_d != '0);
            if (produce) begin
                out_valid <= 1'b1;
                out_last  <= (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
                top_ok    <= (orow_q != '0);
                bot_ok    <= (orow_q != ROW_LAST);
                lft_ok    <= (ocol_q != '0);
                rgt_ok    <= (ocol_q != COL_LAST);
                if (ocol_q == COL_LAST) begin
                    ocol_q <= '0;
                    orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
                end else begin
                    ocol_q <= ocol_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign pix      = (state_q == FLUSH) ? 1'b0 : in_pixel;
    assign shift_en = in_xfer || ((state_q == FLUSH) && produce);

    // Line buffers and window; window centre is the pixel IMG_WIDTH+1 behind the newest
    always_ff @(posedge clk) begin
        if (shift_en) begin
            lb0     <= {lb0[IMG_WIDTH-2:0], pix};
            lb1     <= {lb1[IMG_WIDTH-2:0], lb0[IMG_WIDTH-1]};
            win_top <= {win_top[1:0], lb1[IMG_WIDTH-1]};
            win_mid <= {win_mid[1:0], lb0[IMG_WIDTH-1]};
            win_bot <= {win_bot[1:0], pix};
        end
    end

    // Edge rule on the masked neighbourhood of the presented pixel
    always_comb begin
        c_px  = win_mid[1];
        n_px  = win_top[1] & top_ok;
        s_px  = win_bot[1] & bot_ok;
        w_px  = win_mid[2] & lft_ok;
        e_px  = win_mid[0] & rgt_ok;
        nw_px = win_top[2] & top_ok & lft_ok;
        ne_px = win_top[0] & top_ok & rgt_ok;
        sw_px = win_bot[2] & bot_ok & lft_ok;
        se_px = win_bot[0] & bot_ok & rgt_ok;
        cross_cnt = 3'(n_px) + 3'(e_px) + 3'(s_px) + 3'(w_px);
        if (MODE == 0) begin
            edge_c = c_px && (cross_cnt == 3'd2) && !(nw_px || ne_px || sw_px || se_px);
        end else begin
            edge_c = c_px && (cross_cnt != 3'd4);
        end
    end

    // Window only moves when a new output is loaded, so this holds during stalls
    assign out_edge = out_valid && edge_c;

endmodule

// File: tb/tb_edge_detection_stream.sv
// Directed bench for edge_detection_stream on a 4x4 image, both rule modes.
module tb_edge_detection_stream;
    logic clk, rst, in_valid, in_pixel, out_ready;
    logic in_ready0, out_valid0, out_edge0, out_last0, busy0;
    logic in_ready1, out_valid1, out_edge1, out_last1, busy1;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    int n_in   = 0;
    logic e0_log [256];
    logic e1_log [256];
    logic last_log [256];
    int   nin_log [256];

    edge_detection_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_edge(out_edge0),
        .out_last(out_last0), .out_ready(out_ready), .busy(busy0));

    edge_detection_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_edge(out_edge1),
        .out_last(out_last1), .out_ready(out_ready), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic px(input logic [15:0] img, input int r, input int c);
        if (r < 0 || r > 3 || c < 0 || c > 3) return 1'b0;
        return img[r*4+c];
    endfunction

    // Reference edge map, bit index = raster index
    function automatic logic [15:0] golden(input logic [15:0] img, input int mode);
        logic [15:0] res;
        int nb, cn;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                nb = int'(px(img, r-1, c)) + int'(px(img, r+1, c)) + int'(px(img, r, c-1)) + int'(px(img, r, c+1));
                cn = int'(px(img, r-1, c-1)) + int'(px(img, r-1, c+1)) + int'(px(img, r+1, c-1)) + int'(px(img, r+1, c+1));
                if (mode == 0) res[r*4+c] = px(img, r, c) && nb == 2 && cn == 0;
                else           res[r*4+c] = px(img, r, c) && nb < 4;
            end
        end
        return res;
    endfunction

    // Output/input transfer logger; handshakes are stable at the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0 && out_ready) begin
                if (n_out < 256) begin
                    e0_log[n_out]   = out_edge0;
                    e1_log[n_out]   = out_edge1;
                    last_log[n_out] = out_last0;
                    nin_log[n_out]  = n_in;
                end
                n_out++;
            end
            if (in_valid && in_ready0) n_in++;
        end
    end

    // Streams n_px pixels; optional 5-cycle output stall once stall_k pixels are in
    task automatic send_frame(input logic [15:0] img, input int n_px, input int stall_k,
                              input logic [15:0] exp0, output int low_cnt, output int nout_first);
        int k, guard, stall_left, snap;
        bit stalled, first_done;
        logic hold_edge;
        k = 0; guard = 0; stall_left = 0; stalled = 0; first_done = 0;
        low_cnt = 0; nout_first = -1; hold_edge = 1'b0; snap = n_out;
        in_valid = 1'b1;
        in_pixel = img[0];
        while (k < n_px && guard < 400) begin
            @(negedge clk);
            guard++;
            if (stall_left > 0) begin
                check("stall_in_ready", 32'(in_ready0), 0);
                check("stall_valid", 32'(out_valid0), 1);
                check("stall_edge", 32'(out_edge0), 32'(hold_edge));
                check("stall_last", 32'(out_last0), 0);
                stall_left--;
            end
            if (in_ready0) begin
                if (!first_done) begin
                    first_done = 1;
                    nout_first = snap;
                end
                k++;
            end else if (!first_done) begin
                low_cnt++;
            end
            @(posedge clk); #1;
            snap = n_out;
            out_ready = (stall_left == 0);
            if (!stalled && k == stall_k) begin
                int idx;
                idx = stall_k - 6;
                stalled = 1;
                stall_left = 5;
                out_ready = 1'b0;
                hold_edge = exp0[idx];
            end
            if (k < n_px) in_pixel = img[k];
            else          in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("send_done", 32'(k), 32'(n_px));
    endtask

    task automatic wait_outputs(input int target);
        int guard;
        guard = 0;
        while (n_out < target && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("out_count", 32'(n_out), 32'(target));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] exp0, input logic [15:0] exp1);
        logic [15:0] g0, g1, gl;
        for (int i = 0; i < 16; i++) begin
            g0[i] = e0_log[base+i];
            g1[i] = e1_log[base+i];
            gl[i] = last_log[base+i];
        end
        check({tag, "_mode0"}, 32'(g0), 32'(exp0));
        check({tag, "_mode1"}, 32'(g1), 32'(exp1));
        check({tag, "_last"}, 32'(gl), 32'h8000);
    endtask

    // Runs one full frame and checks it
    task automatic run_frame(input string tag, input logic [15:0] img, input int stall_k,
                             input logic [15:0] exp0, input logic [15:0] exp1);
        int base, low, nf;
        base = n_out;
        send_frame(img, 16, stall_k, exp0, low, nf);
        wait_outputs(base + 16);
        check_frame(tag, base, exp0, exp1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_no_extra"}, 32'(n_out), 32'(base + 16));
    endtask

    initial begin
        int base, in_base, low, nf;
        logic [15:0] img;
        rst = 1'b1; in_valid = 1'b0; in_pixel = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'({in_ready0, in_ready1}), 0);
        check("rst_out_valid", 32'({out_valid0, out_valid1}), 0);
        check("rst_out_edge", 32'({out_edge0, out_edge1}), 0);
        check("rst_out_last", 32'({out_last0, out_last1}), 0);
        check("rst_busy", 32'({busy0, busy1}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'({in_ready0, in_ready1}), 32'h3);
        @(posedge clk); #1;

        // All-zero frame, with fill latency and idle-after-frame status
        base = n_out; in_base = n_in;
        send_frame(16'h0000, 16, -1, 16'h0, low, nf);
        wait_outputs(base + 16);
        check_frame("zero", base, 16'h0000, 16'h0000);
        check("first_out_inputs", 32'(nin_log[base] - in_base), 6);
        check("idle_busy", 32'(busy0), 0);
        check("idle_in_ready", 32'(in_ready0), 1);

        run_frame("col1", 16'h2222, -1, 16'h0220, 16'h2222);
        run_frame("ones", 16'hFFFF, -1, 16'h0000, 16'hF99F);

        img = 16'($urandom());
        run_frame("rand_stall", img, 9, golden(img, 0), golden(img, 1));

        // Reset in the middle of a frame, then a clean frame
        send_frame(16'hFFFF, 7, -1, 16'h0, low, nf);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid0), 0);
        check("midrst_busy", 32'(busy0), 0);
        check("midrst_in_ready", 32'(in_ready0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_ready", 32'(in_ready0), 1);
        @(posedge clk); #1;
        img = 16'h5A3C;
        run_frame("after_rst", img, -1, golden(img, 0), golden(img, 1));

        // Back-to-back frames with in_valid held high across the boundary
        base = n_out;
        send_frame(16'h0660, 16, -1, 16'h0, low, nf);
        send_frame(16'h2222, 16, -1, 16'h0, low, nf);
        check("b2b_ready_low", 32'(low), 6);
        check("b2b_first_accept", 32'(nf), 32'(base + 16));
        wait_outputs(base + 32);
        check_frame("b2b_f1", base, 16'h0000, 16'h0660);
        check_frame("b2b_f2", base + 16, 16'h0220, 16'h2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
